// File: rtl/lane_pkg.sv
// Shared constants and types for the 8-lane collector.
package lane_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned W     = 2;
  localparam int unsigned SELW  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef logic [SELW-1:0] lane_idx_t;

  // One output beat: source lane, payload and end-of-packet flag.
  typedef struct packed {
    lane_idx_t       sel;
    logic [W-1:0]    data;
    logic            last;
  } beat_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority picker: first requesting lane at or after ptr, wrapping mod 8.
module rr_pick8
  import lane_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  lane_idx_t        ptr,
  output logic [LANES-1:0] gnt_onehot,
  output lane_idx_t        gnt_idx,
  output logic             any
);

  lane_idx_t idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    // 3-bit addition wraps naturally past lane 7.
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = ptr + lane_idx_t'(k);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_collect8.sv
// Merges 8 narrow valid/ready lanes into one tagged stream with round-robin
// arbitration; a lane holds the grant until the last beat of its packet.
module lane_collect8
  import lane_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES-1:0]   in_valid,
  input  logic [LANES-1:0]   in_last,
  input  logic [LANES*W-1:0] in_data,
  output logic [LANES-1:0]   in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output lane_idx_t          out_sel,
  output logic               out_last,
  input  logic               out_ready
);

  state_t           state, state_nxt;
  lane_idx_t        rr_ptr, rr_ptr_nxt;
  lane_idx_t        owner, owner_nxt;
  lane_idx_t        pick_ptr, gnt_idx;
  logic [LANES-1:0] req, gnt_onehot;
  logic             pick_any, load_ok, accept;
  logic [W-1:0]     beat_data;
  beat_t            out_q;

  assign load_ok = !out_valid || out_ready;

  // While locked only the owner may request; picking from owner makes it win.
  always_comb begin
    req      = in_valid;
    pick_ptr = rr_ptr;
    if (state == ST_LOCK) begin
      req      = in_valid & (LANES'(1) << owner);
      pick_ptr = owner;
    end
  end

  rr_pick8 u_pick (
    .req        (req),
    .ptr        (pick_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (pick_any)
  );

  assign accept   = pick_any && load_ok && !reset;
  assign in_ready = accept ? gnt_onehot : '0;

  always_comb begin
    beat_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (gnt_idx == lane_idx_t'(i)) beat_data = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_last[gnt_idx]) begin
            rr_ptr_nxt = gnt_idx + lane_idx_t'(1);
          end else begin
            owner_nxt = gnt_idx;
            state_nxt = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (accept && in_last[gnt_idx]) begin
          rr_ptr_nxt = owner + lane_idx_t'(1);
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single output register; a new beat may replace one draining this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_q.sel  <= gnt_idx;
      out_q.data <= beat_data;
      out_q.last <= in_last[gnt_idx];
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_sel  = out_q.sel;
  assign out_data = out_q.data;
  assign out_last = out_q.last;

endmodule

// File: tb/tb_lane_collect8.sv
// Scenario bench for lane_collect8: expected beats are queued as stimulus is
// driven and matched against every output transfer.
module tb_lane_collect8;

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] data;
    logic       last;
  } exp_beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_valid;
  logic [7:0]  in_last;
  logic [15:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [1:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_last;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  exp_beat_t sb[$];

  lane_collect8 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard: every output transfer must match the oldest queued beat.
  always @(negedge clk) begin
    exp_beat_t e;
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_beat: got sel=%0d data=%0d last=%0d, expected none",
                 out_sel, out_data, out_last);
      end else begin
        e = sb.pop_front();
        if ({out_sel, out_data, out_last} !== {e.sel, e.data, e.last})
          $display("FAIL beat: got sel=%0d data=%0d last=%0d, expected sel=%0d data=%0d last=%0d",
                   out_sel, out_data, out_last, e.sel, e.data, e.last);
        else
          n_pass++;
      end
    end
  end

  task automatic push(input int sel, input int data, input bit last);
    exp_beat_t e;
    e.sel  = 3'(sel);
    e.data = 2'(data);
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic set_lane(input int lane, input int d);
    in_data[lane*2 +: 2] = 2'(d);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 8'hFF;
    in_last   = 8'hFF;
    in_data   = 16'hFFFF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 8'h00) $display("FAIL reset_in_ready: got %h, expected 00", in_ready);
    else n_pass++;
    n_checks++;
    if ({out_valid, out_sel, out_data, out_last} !== 7'b0)
      $display("FAIL reset_outputs: got valid=%b sel=%0d data=%0d last=%b, expected all 0",
               out_valid, out_sel, out_data, out_last);
    else n_pass++;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 8'h00 || out_valid !== 1'b0)
        $display("FAIL idle_quiet: cycle %0d in_ready=%h out_valid=%b, expected 00 and 0",
                 c, in_ready, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int got = 0;
    logic [7:0] exp_rdy;
    do_reset();
    in_data  = 16'hE4E4;
    in_last  = 8'hFF;
    in_valid = 8'hFF;
    for (int k = 0; k < 12; k++) push(k % 8, k % 4, 1'b1);
    for (int c = 0; c < 40 && got < 12; c++) begin
      @(negedge clk);
      exp_rdy = 8'(1) << (got % 8);
      n_checks++;
      if (in_ready !== exp_rdy)
        $display("FAIL rr_grant: beat %0d in_ready=%h, expected %h", got, in_ready, exp_rdy);
      else n_pass++;
      if (in_ready != 8'h00) got++;
      @(posedge clk); #1;
      if (got == 12) in_valid = '0;
    end
    in_valid = '0;
    n_checks++;
    if (got !== 12) $display("FAIL rr_timeout: accepted %0d, expected 12", got);
    else n_pass++;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin @(negedge clk); #1; end
    n_checks++;
    if (sb.size() != 0) $display("FAIL rr_drain: %0d beats outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_lock();
    int got = 0;
    int n5  = 0;
    int gap = 0;
    int order[5] = '{5, 5, 5, 6, 2};
    logic [7:0] rdy, exp_rdy;
    do_reset();
    // A single lane-4 packet leaves the pointer at 5.
    in_valid = 8'h10; in_last = 8'h10; set_lane(4, 3);
    push(4, 3, 1'b1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h10) $display("FAIL lock_setup: in_ready=%h, expected 10", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 8'h64; in_last = 8'h44;
    set_lane(2, 2); set_lane(5, 0); set_lane(6, 1);
    push(5, 0, 1'b0); push(5, 1, 1'b0); push(5, 2, 1'b1); push(6, 1, 1'b1); push(2, 2, 1'b1);
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      rdy     = in_ready;
      exp_rdy = (gap > 0) ? 8'h00 : (8'(1) << order[got]);
      n_checks++;
      if (rdy !== exp_rdy)
        $display("FAIL lock_grant: step %0d in_ready=%h, expected %h", got, rdy, exp_rdy);
      else n_pass++;
      if (n5 < 3) begin
        n_checks++;
        if ((rdy & 8'h44) !== 8'h00)
          $display("FAIL lock_block: in_ready=%h, expected lanes 2/6 low", rdy);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (gap > 0) begin
        gap--;
        if (gap == 0) in_valid[5] = 1'b1;
      end else if (rdy != 8'h00) begin
        got++;
        if (rdy[5]) begin
          n5++;
          set_lane(5, n5);
          in_last[5] = (n5 == 2);
          if (n5 == 1) begin in_valid[5] = 1'b0; gap = 2; end
          if (n5 == 3) in_valid[5] = 1'b0;
        end
        if (rdy[6]) in_valid[6] = 1'b0;
        if (rdy[2]) in_valid[2] = 1'b0;
      end
    end
    in_valid = '0;
    n_checks++;
    if (got !== 5) $display("FAIL lock_timeout: accepted %0d, expected 5", got);
    else n_pass++;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin @(negedge clk); #1; end
    n_checks++;
    if (sb.size() != 0) $display("FAIL lock_drain: %0d beats outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 8'h08; in_last = 8'h08; set_lane(3, 1);
    push(3, 1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h08) $display("FAIL bp_first: in_ready=%h, expected 08", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    set_lane(3, 2);
    push(3, 2, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 2'd1 || in_ready !== 8'h00)
        $display("FAIL bp_hold: cycle %0d valid=%b sel=%0d data=%0d in_ready=%h, expected 1/3/1/00",
                 c, out_valid, out_sel, out_data, in_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h08) $display("FAIL bp_release: in_ready=%h, expected 08", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 2'd2)
      $display("FAIL bp_next: valid=%b data=%0d, expected 1/2", out_valid, out_data);
    else n_pass++;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin @(negedge clk); #1; end
    n_checks++;
    if (sb.size() != 0) $display("FAIL bp_drain: %0d beats outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    int got = 0;
    logic [7:0] exp_rdy;
    do_reset();
    // A single lane-6 packet leaves the pointer at 7.
    in_valid = 8'h40; in_last = 8'h40; set_lane(6, 3);
    push(6, 3, 1'b1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h40) $display("FAIL wrap_setup: in_ready=%h, expected 40", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 8'h81; in_last = 8'h81; set_lane(7, 2); set_lane(0, 1);
    push(7, 2, 1'b1); push(0, 1, 1'b1); push(7, 2, 1'b1); push(0, 1, 1'b1);
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      exp_rdy = (got % 2 == 0) ? 8'h80 : 8'h01;
      n_checks++;
      if (in_ready !== exp_rdy)
        $display("FAIL wrap_grant: beat %0d in_ready=%h, expected %h", got, in_ready, exp_rdy);
      else n_pass++;
      if (in_ready != 8'h00) got++;
      @(posedge clk); #1;
      if (got == 4) in_valid = '0;
    end
    in_valid = '0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin @(negedge clk); #1; end
    n_checks++;
    if (sb.size() != 0) $display("FAIL wrap_drain: %0d beats outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b0;
    in_valid = 8'h10; in_last = 8'h00; set_lane(4, 2);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h10) $display("FAIL mid_lock: in_ready=%h, expected 10", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 8'h12; in_last = 8'h02; set_lane(1, 1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 8'h00)
      $display("FAIL mid_held: valid=%b in_ready=%h, expected 1/00", out_valid, in_ready);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 8'h00)
      $display("FAIL mid_reset: valid=%b in_ready=%h, expected 0/00", out_valid, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push(1, 1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 8'h02) $display("FAIL mid_regrant: in_ready=%h, expected 02", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = '0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin @(negedge clk); #1; end
    n_checks++;
    if (sb.size() != 0) $display("FAIL mid_drain: %0d beats outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
